vecmat_add_sched: RTL and testbench
===================================

Name: vecmat_add_sched

Overview:
- Sequencer for the 64-lane, 16-bit fixed-point reduction tree that sums 64 products per beat.
- Accepts a job of ROWS rows, each made of CHUNKS beats of 64 products. Each accepted beat is driven into the free-running tree, and the tree's 2-cycle result stream is tracked with tags.
- Results are accumulated per row and pushed into an output FIFO with valid/ready.
- Sits between the multiplier array and the softmax/output buffer in the attention layer.

Parameters:
- LANES, 64, products per beat (tree width).
- DW, 16, data width of each product and of each result.
- TREE_LAT, 2, cycles from tree_in to tree_result (input-to-flop stage plus output register).
- FIFO_DEPTH, 4, output FIFO entries (power of 2).
- RW, 6, width of rows and row-index fields.
- CW, 4, width of the chunks field.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-low reset.
- start  in  1  job start; sampled only in IDLE.
- num_rows  in  RW  rows in the job; 0 is legal.
- chunks_per_row  in  CW  beats per row; 0 is treated as 1.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse at job end.
- in_valid  in  1  product beat valid.
- in_ready  out  1  beat accepted when in_valid && in_ready.
- in_data  in  LANES*DW  64 packed products; lane k is bits [16k+:16].
- tree_in  out  LANES*DW  drives the tree input bus.
- tree_result  in  DW  tree output.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  consumer ready.
- out_data  out  DW  row sum.
- out_row  out  RW  row index of out_data.
- out_last  out  1  marks the final row of the job.

Behaviour:
- Reset (reset==0 at a clk edge) applies regardless of state:
  - State goes to IDLE.
  - Outputs: busy=0, done=0, in_ready=0, out_valid=0, tree_in=0, out_data=0, out_row=0, out_last=0.
  - FIFO is flushed; tag pipeline, counters and accumulator are cleared.
  - A job in flight is abandoned; results already in the tree are discarded.
- Configuration is latched on start in IDLE. start is ignored outside IDLE.
- States:
  - IDLE: start && num_rows==0 goes directly to DONE. Otherwise start goes to RUN with row_cnt=0 and chunk_cnt=0.
  - RUN:
    - in_ready = (fifo_count + pend_rows < FIFO_DEPTH), where pend_rows = number of last-tags in the tag pipeline, plus 1 if the accumulator holds a row that is not yet pushed. This credit check makes overflow impossible.
    - On each accepted beat: tree_in=in_data, and a tag {v=1, first=(chunk_cnt==0), last=(chunk_cnt==chunks-1), row=row_cnt} enters the TREE_LAT-deep tag shift register.
    - chunk_cnt wraps to 0 at the end of a row, and row_cnt then increments.
    - Acceptance of the last beat of the last row goes to DRAIN.
    - When no beat is accepted, tree_in=0 and an invalid tag enters the shift register.
  - DRAIN: in_ready=0. Moves to DONE when the tag pipeline holds no valid tag and the final push has occurred. FIFO emptiness is not required.
  - DONE: done=1 for exactly one cycle, then IDLE. A start in the DONE cycle is ignored.
- Tag exit happens in the cycle a tag leaves the shift register, aligned with its tree_result:
  - acc_next = first ? tree_result : sat16(acc + tree_result).
  - sat16 is two's-complement saturation: the result clamps to 0x7FFF or 0x8000.
  - If last: push {acc_next, row, row==rows-1} into the FIFO.
- FIFO:
  - Show-ahead; out_data/out_row/out_last are valid whenever out_valid=1.
  - Pop when out_valid && out_ready.
  - A push and a pop in the same cycle are both honoured, including when the FIFO is full (a pop frees the slot) or empty (a push is visible next cycle).
  - Outputs hold stable while out_valid && !out_ready.
- Latency: last beat of a row accepted at cycle t → row visible at out_valid at cycle t+TREE_LAT+1 when the FIFO is empty.
- Throughput: 1 beat/cycle sustained while out_ready=1.

Test Plan:
- Single row, single chunk: rows=1, chunks=1, all 64 lanes=0x0001 → one output {0x0040, row 0, last=1} 3 cycles after acceptance; done pulses once; busy drops.
- Multi-chunk accumulation: rows=2, chunks=3, lanes=0x0002 → outputs 0x0180 (row 0) then 0x0180 (row 1, last=1); in_ready held high throughout with out_ready=1.
- Saturation: rows=1, chunks=4, beats whose tree sum is 0x4000 each → output 0x7FFF. With negative sums of 0xC000 each → output 0x8000.
- Backpressure: rows=8, chunks=1, out_ready=0 → exactly 4 beats accepted, then in_ready=0. Releasing out_ready → all 8 rows delivered in order 0..7 with no loss or duplication.
- Zero-row job and ignored start: rows=0 → done one cycle after start, no output. A start pulse mid-RUN → no effect on counters.
- Reset mid-job: assert reset=0 during RUN with 2 results in the FIFO → next cycle all outputs are at reset values and the FIFO is empty. A new job then completes with correct sums.

Source files
------------

// File: rtl/vecmat_add_sched.sv
// vecmat_add_sched: job sequencer for the 64-lane reduction tree.
// Feeds product beats into the free-running tree, tracks the fixed-latency
// result stream with tags, accumulates per-row sums with saturation and
// queues finished rows in a small show-ahead output FIFO.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | waiting for start; configuration latched on start
// ST_RUN   | accepting beats, gated by output credit
// ST_DRAIN | all beats accepted; waiting for the tree/tags to empty
// ST_DONE  | one-cycle done pulse, then back to idle
module vecmat_add_sched #(
    parameter int LANES      = 64,
    parameter int DW         = 16,
    parameter int TREE_LAT   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int RW         = 6,
    parameter int CW         = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [RW-1:0]         num_rows,
    input  logic [CW-1:0]         chunks_per_row,
    output logic                  busy,
    output logic                  done,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*DW-1:0]   in_data,
    output logic [LANES*DW-1:0]   tree_in,
    input  logic [DW-1:0]         tree_result,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DW-1:0]         out_data,
    output logic [RW-1:0]         out_row,
    output logic                  out_last
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = DW + RW + 1;
    localparam int SW = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic          v;
        logic          first;
        logic          last;
        logic [RW-1:0] row;
    } tag_t;

    state_t        state;
    state_t        state_next;

    logic [RW-1:0] rows_m1;
    logic [RW-1:0] row_cnt;
    logic [CW-1:0] chunks_m1;
    logic [CW-1:0] chunk_cnt;
    logic          final_pushed;

    tag_t          tag_sr [TREE_LAT];
    tag_t          tag_new;
    tag_t          tag_exit;
    logic          any_tag;

    logic [DW-1:0] acc;
    logic [DW-1:0] acc_next;
    logic [DW-1:0] acc_sat;
    logic [DW:0]   acc_sum;
    logic          acc_pend;

    logic [EW-1:0] fifo_mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   fifo_cnt;
    logic [EW-1:0] push_entry;
    logic [EW-1:0] head;

    logic [SW-1:0] pend_rows;
    logic [SW-1:0] credit_used;

    logic          accept;
    logic          beat_first;
    logic          beat_last;
    logic          job_last_beat;
    logic          push;
    logic          push_last;
    logic          pop;

    // Outstanding output slots: rows already queued, rows whose last tag is
    // still in flight, and a partially accumulated row.
    always_comb begin
        pend_rows = SW'(acc_pend);
        any_tag   = 1'b0;
        for (int i = 0; i < TREE_LAT; i++) begin
            pend_rows = pend_rows + SW'(tag_sr[i].v && tag_sr[i].last);
            any_tag   = any_tag | tag_sr[i].v;
        end
        credit_used = SW'(fifo_cnt) + pend_rows;
    end

    assign in_ready      = (state == ST_RUN) && (credit_used < SW'(FIFO_DEPTH));
    assign accept        = in_valid && in_ready;
    assign beat_first    = (chunk_cnt == '0);
    assign beat_last     = (chunk_cnt == chunks_m1);
    assign job_last_beat = accept && beat_last && (row_cnt == rows_m1);

    // The tree is free-running, so idle cycles must present zeros.
    assign tree_in = accept ? in_data : '0;

    // Tag for the beat entering the tree this cycle (invalid when idle).
    always_comb begin
        tag_new = '0;
        if (accept) begin
            tag_new.v     = 1'b1;
            tag_new.first = beat_first;
            tag_new.last  = beat_last;
            tag_new.row   = row_cnt;
        end
    end

    assign tag_exit = tag_sr[TREE_LAT-1];

    // Tag shift register, depth matches the tree latency.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < TREE_LAT; i++) begin
                tag_sr[i] <= '0;
            end
        end else begin
            tag_sr[0] <= tag_new;
            for (int i = 1; i < TREE_LAT; i++) begin
                tag_sr[i] <= tag_sr[i-1];
            end
        end
    end

    // Saturating two's-complement accumulate of the aligned tree result.
    always_comb begin
        acc_sum = {acc[DW-1], acc} + {tree_result[DW-1], tree_result};
        if (acc_sum[DW] != acc_sum[DW-1]) begin
            acc_sat = {acc_sum[DW], {(DW-1){~acc_sum[DW]}}};
        end else begin
            acc_sat = acc_sum[DW-1:0];
        end
        acc_next = tag_exit.first ? tree_result : acc_sat;
    end

    assign push       = tag_exit.v && tag_exit.last;
    assign push_last  = (tag_exit.row == rows_m1);
    assign push_entry = {push_last, tag_exit.row, acc_next};

    // Accumulator and the flag marking a row that is started but not queued.
    always_ff @(posedge clk) begin
        if (!reset) begin
            acc      <= '0;
            acc_pend <= 1'b0;
        end else if (tag_exit.v) begin
            acc      <= acc_next;
            acc_pend <= !tag_exit.last;
        end
    end

    // Job configuration and beat position counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            rows_m1   <= '0;
            chunks_m1 <= '0;
            row_cnt   <= '0;
            chunk_cnt <= '0;
        end else if ((state == ST_IDLE) && start) begin
            rows_m1   <= num_rows - RW'(1);
            chunks_m1 <= (chunks_per_row == '0) ? '0 : chunks_per_row - CW'(1);
            row_cnt   <= '0;
            chunk_cnt <= '0;
        end else if (accept) begin
            if (beat_last) begin
                chunk_cnt <= '0;
                row_cnt   <= row_cnt + RW'(1);
            end else begin
                chunk_cnt <= chunk_cnt + CW'(1);
            end
        end
    end

    // Records that the final row of the job has been queued.
    always_ff @(posedge clk) begin
        if (!reset) begin
            final_pushed <= 1'b0;
        end else if ((state == ST_IDLE) && start) begin
            final_pushed <= 1'b0;
        end else if (push && push_last) begin
            final_pushed <= 1'b1;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = (num_rows == '0) ? ST_DONE : ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (job_last_beat) begin
                    state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                busy = 1'b1;
                if (!any_tag && final_pushed) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done       = 1'b1;
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign out_valid = (fifo_cnt != '0);
    assign pop       = out_valid && out_ready;
    assign head      = fifo_mem[rd_ptr];
    assign out_data  = out_valid ? head[DW-1:0]  : '0;
    assign out_row   = out_valid ? head[DW+:RW]  : '0;
    assign out_last  = out_valid && head[EW-1];

    // Output FIFO storage; contents are don't-care while the slot is empty.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= push_entry;
        end
    end

    // Output FIFO pointers and occupancy; push and pop may coincide.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + (AW+1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (AW+1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

endmodule

// File: tb/tb_vecmat_add_sched.sv
// Directed bench for vecmat_add_sched with a behavioural 2-cycle reduction tree.
module tb_vecmat_add_sched;

    localparam int LANES = 64;
    localparam int DW    = 16;
    localparam int RW    = 6;
    localparam int CW    = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic                start;
    logic [RW-1:0]       num_rows;
    logic [CW-1:0]       chunks_per_row;
    logic                busy;
    logic                done;
    logic                in_valid;
    logic                in_ready;
    logic [LANES*DW-1:0] in_data;
    logic [LANES*DW-1:0] tree_in;
    logic [DW-1:0]       tree_result;
    logic                out_valid;
    logic                out_ready;
    logic [DW-1:0]       out_data;
    logic [RW-1:0]       out_row;
    logic                out_last;

    logic [DW-1:0]       tr_s1 = '0;
    logic [DW-1:0]       tr_out = '0;

    int n_vec = 0;
    int n_bad = 0;
    int beats = 0;
    int done_cnt = 0;
    logic [22:0] outq [$];

    vecmat_add_sched dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .num_rows       (num_rows),
        .chunks_per_row (chunks_per_row),
        .busy           (busy),
        .done           (done),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .tree_in        (tree_in),
        .tree_result    (tree_result),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .out_row        (out_row),
        .out_last       (out_last)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] tree_sum(input logic [LANES*DW-1:0] b);
        logic [DW-1:0] s;
        s = '0;
        for (int k = 0; k < LANES; k++) s = s + b[16*k +: 16];
        return s;
    endfunction

    // Model of the external tree: input flop stage plus output register.
    always @(posedge clk) begin
        tr_s1  <= tree_sum(tree_in);
        tr_out <= tr_s1;
    end
    assign tree_result = tr_out;

    function automatic logic [LANES*DW-1:0] fill(input logic [DW-1:0] v);
        logic [LANES*DW-1:0] r;
        for (int k = 0; k < LANES; k++) r[16*k +: 16] = v;
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_vec++;
        assert (obs === want) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    // One clock: sample handshakes, then advance to 1 time unit past the edge.
    task automatic tick();
        #1;
        if (in_valid && in_ready) beats++;
        if (out_valid && out_ready) outq.push_back({out_last, out_row, out_data});
        if (done) done_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int rows, input int chunks);
        num_rows       = RW'(rows);
        chunks_per_row = CW'(chunks);
        start          = 1'b1;
        tick();
        start          = 1'b0;
    endtask

    task automatic send(input int n, input logic [DW-1:0] v);
        int b0;
        int guard;
        b0 = beats;
        guard = 0;
        in_valid = 1'b1;
        in_data  = fill(v);
        while ((beats - b0) < n && guard < n * 20 + 20) begin
            tick();
            guard++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        check("send_count", 32'(beats - b0), 32'(n));
    endtask

    task automatic wait_done(input int max_cyc);
        int d0;
        int i;
        d0 = done_cnt;
        i = 0;
        while (done_cnt == d0 && i < max_cyc) begin
            tick();
            i++;
        end
        check("done_pulses", 32'(done_cnt - d0), 32'd1);
        check("done_after", 32'(done), 32'd0);
        check("busy_after", 32'(busy), 32'd0);
    endtask

    task automatic check_out(input string tag, input int idx, input logic [22:0] want);
        logic [22:0] obs;
        obs = (idx < outq.size()) ? outq[idx] : '1;
        check(tag, 32'(obs), 32'(want));
    endtask

    initial begin
        logic [LANES*DW-1:0] exp_bus;
        int b0;
        int guard;

        reset = 1'b0; start = 1'b0; num_rows = '0; chunks_per_row = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_tree_in", 32'(tree_in == '0), 32'd1);
        check("rst_out_fields", 32'({out_last, out_row, out_data}), 32'd0);
        reset = 1'b1;
        tick();

        // Single row, single chunk, lanes = 1 -> 0x0040 three cycles after acceptance.
        start_job(1, 1);
        check("t1_busy", 32'(busy), 32'd1);
        check("t1_in_ready", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = fill(16'h0001);
        exp_bus  = fill(16'h0001);
        #1;
        check("t1_tree_in", 32'(tree_in == exp_bus), 32'd1);
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        check("t1_lat1", 32'(out_valid), 32'd0);
        tick();
        check("t1_lat2", 32'(out_valid), 32'd0);
        tick();
        check("t1_lat3", 32'(out_valid), 32'd1);
        check("t1_head", 32'({out_last, out_row, out_data}), 32'({1'b1, 6'd0, 16'h0040}));
        wait_done(10);
        check("t1_hold", 32'({out_valid, out_last, out_row, out_data}), 32'({1'b1, 1'b1, 6'd0, 16'h0040}));
        out_ready = 1'b1;
        tick();
        check("t1_nout", 32'(outq.size()), 32'd1);
        check_out("t1_out0", 0, {1'b1, 6'd0, 16'h0040});
        check("t1_empty", 32'(out_valid), 32'd0);
        outq.delete();

        // Two rows of three chunks, lanes = 2 -> 0x0180 per row, no stalls.
        start_job(2, 3);
        b0 = beats;
        in_valid = 1'b1;
        in_data  = fill(16'h0002);
        for (int i = 0; i < 6; i++) begin
            #1;
            check("t2_in_ready", 32'(in_ready), 32'd1);
            tick();
        end
        in_valid = 1'b0;
        in_data  = '0;
        check("t2_beats", 32'(beats - b0), 32'd6);
        wait_done(20);
        tick(); tick();
        check("t2_nout", 32'(outq.size()), 32'd2);
        check_out("t2_out0", 0, {1'b0, 6'd0, 16'h0180});
        check_out("t2_out1", 1, {1'b1, 6'd1, 16'h0180});
        outq.delete();

        // Positive saturation: four beats of 0x4000.
        start_job(1, 4);
        send(4, 16'h0100);
        wait_done(20);
        tick(); tick();
        check("t3_nout_pos", 32'(outq.size()), 32'd1);
        check_out("t3_sat_pos", 0, {1'b1, 6'd0, 16'h7FFF});
        outq.delete();

        // Negative saturation: four beats of 0xC000.
        start_job(1, 4);
        send(4, 16'hFF00);
        wait_done(20);
        tick(); tick();
        check("t3_nout_neg", 32'(outq.size()), 32'd1);
        check_out("t3_sat_neg", 0, {1'b1, 6'd0, 16'h8000});
        outq.delete();

        // Backpressure: eight single-chunk rows with the consumer stalled.
        out_ready = 1'b0;
        start_job(8, 1);
        b0 = beats;
        in_valid = 1'b1;
        in_data  = fill(16'h0001);
        repeat (10) tick();
        check("t4_stalled_beats", 32'(beats - b0), 32'd4);
        check("t4_in_ready_low", 32'(in_ready), 32'd0);
        check("t4_head", 32'({out_valid, out_row, out_data}), 32'({1'b1, 6'd0, 16'h0040}));
        out_ready = 1'b1;
        guard = 0;
        while ((beats - b0) < 8 && guard < 60) begin
            tick();
            guard++;
        end
        in_valid = 1'b0;
        in_data  = '0;
        check("t4_beats", 32'(beats - b0), 32'd8);
        wait_done(30);
        tick(); tick();
        check("t4_nout", 32'(outq.size()), 32'd8);
        for (int i = 0; i < 8; i++) begin
            check_out("t4_out", i, {(i == 7), 6'(i), 16'h0040});
        end
        outq.delete();

        // Zero-row job; start held high through the DONE cycle is ignored.
        num_rows       = '0;
        chunks_per_row = 4'd1;
        start          = 1'b1;
        tick();
        check("t5_done", 32'(done), 32'd1);
        check("t5_busy", 32'(busy), 32'd0);
        tick();
        start = 1'b0;
        check("t5_done_once", 32'(done), 32'd0);
        tick();
        check("t5_idle", 32'({busy, done}), 32'd0);
        check("t5_nout", 32'(outq.size()), 32'd0);

        // Start pulse during RUN must not disturb the latched job.
        start_job(2, 2);
        b0 = beats;
        in_valid = 1'b1;
        in_data  = fill(16'h0003);
        tick();
        start          = 1'b1;
        num_rows       = 6'd5;
        chunks_per_row = 4'd1;
        tick();
        start          = 1'b0;
        send(2, 16'h0003);
        wait_done(20);
        tick(); tick();
        check("t5_run_beats", 32'(beats - b0), 32'd4);
        check("t5_run_nout", 32'(outq.size()), 32'd2);
        check_out("t5_run_out0", 0, {1'b0, 6'd0, 16'h0180});
        check_out("t5_run_out1", 1, {1'b1, 6'd1, 16'h0180});
        outq.delete();

        // Reset in RUN with two rows waiting in the FIFO.
        out_ready = 1'b0;
        start_job(4, 1);
        send(2, 16'h0001);
        tick(); tick(); tick();
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        reset    = 1'b0;
        in_valid = 1'b1;
        in_data  = fill(16'h0007);
        tick();
        #1;
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd0);
        check("t6_tree_in", 32'(tree_in == '0), 32'd1);
        check("t6_out", 32'({out_valid, out_last, out_row, out_data}), 32'd0);
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        tick();
        check("t6_empty", 32'(out_valid), 32'd0);
        outq.delete();
        out_ready = 1'b1;
        start_job(2, 2);
        send(4, 16'h0005);
        wait_done(20);
        tick(); tick();
        check("t6_nout", 32'(outq.size()), 32'd2);
        check_out("t6_out0", 0, {1'b0, 6'd0, 16'h0280});
        check_out("t6_out1", 1, {1'b1, 6'd1, 16'h0280});

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
